// File: rtl/mul_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_queue
// Description : Tagged operand FIFO and one-at-a-time issue controller for
//               the iterative 32x32 multiplier. Optional completion watchdog
//               enabled by defining MUL_ISSUE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_valid_in,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_valid_out,
    input  logic [63:0]      mul_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [31:0]      r_mem_a_q   [DEPTH];
    logic [31:0]      r_mem_b_q   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag_q [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W:0]   r_count_q,  w_count_d;
    logic [1:0]         r_state_q,  w_state_d;
    logic [TAG_W-1:0]   r_tag_q,    w_tag_d;
    logic               r_mul_valid_q, w_mul_valid_d;
    logic [31:0]        r_mul_a_q,  w_mul_a_d;
    logic [31:0]        r_mul_b_q,  w_mul_b_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [63:0]        r_out_r_q,  w_out_r_d;
    logic [TAG_W-1:0]   r_out_tag_q, w_out_tag_d;
`ifdef MUL_ISSUE_TIMEOUT_EN
    // Value seen on the 20th WAIT cycle: the count reaches 20 at that edge.
    localparam logic [4:0] c_WDOG_LAST = 5'd19;
    logic               r_out_err_q, w_out_err_d;
    logic [4:0]         r_wdog_q,   w_wdog_d;
`endif

    logic w_full, w_empty, w_push, w_pop;

    assign w_full   = (r_count_q == c_CNT_FULL);
    assign w_empty  = (r_count_q == '0);
    assign w_push   = in_valid && !w_full;
    assign in_ready = !w_full;

    // Operand storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a_q[r_wr_ptr_q]   <= in_a;
            r_mem_b_q[r_wr_ptr_q]   <= in_b;
            r_mem_tag_q[r_wr_ptr_q] <= in_tag;
        end
    end

    always_comb begin
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        w_state_d     = r_state_q;
        w_tag_d       = r_tag_q;
        w_mul_valid_d = 1'b0;
        w_mul_a_d     = r_mul_a_q;
        w_mul_b_d     = r_mul_b_q;
        w_out_valid_d = r_out_valid_q;
        w_out_r_d     = r_out_r_q;
        w_out_tag_d   = r_out_tag_q;
        w_pop         = 1'b0;
`ifdef MUL_ISSUE_TIMEOUT_EN
        w_out_err_d   = r_out_err_q;
        w_wdog_d      = r_wdog_q;
`endif
        case (r_state_q)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_mul_valid_d = 1'b1;
                    w_mul_a_d     = r_mem_a_q[r_rd_ptr_q];
                    w_mul_b_d     = r_mem_b_q[r_rd_ptr_q];
                    w_tag_d       = r_mem_tag_q[r_rd_ptr_q];
                    w_state_d     = c_ST_WAIT;
`ifdef MUL_ISSUE_TIMEOUT_EN
                    w_wdog_d      = 5'd0;
`endif
                end
            end
            c_ST_WAIT: begin
                // A completion pulse wins over a watchdog expiry in the same cycle.
                if (mul_valid_out) begin
                    w_out_r_d     = mul_r;
                    w_out_tag_d   = r_tag_q;
                    w_out_valid_d = 1'b1;
                    w_state_d     = c_ST_HOLD;
`ifdef MUL_ISSUE_TIMEOUT_EN
                    w_out_err_d   = 1'b0;
                end else if (r_wdog_q == c_WDOG_LAST) begin
                    w_out_r_d     = 64'd0;
                    w_out_tag_d   = r_tag_q;
                    w_out_err_d   = 1'b1;
                    w_out_valid_d = 1'b1;
                    w_state_d     = c_ST_HOLD;
                end else begin
                    w_wdog_d      = r_wdog_q + 5'd1;
`endif
                end
            end
            c_ST_HOLD: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = c_ST_IDLE;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase

        if (w_push) w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        if (w_pop)  w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_ONE;
            2'b01:   w_count_d = r_count_q - c_CNT_ONE;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_count_q     <= '0;
            r_state_q     <= c_ST_IDLE;
            r_tag_q       <= '0;
            r_mul_valid_q <= 1'b0;
            r_mul_a_q     <= 32'd0;
            r_mul_b_q     <= 32'd0;
            r_out_valid_q <= 1'b0;
            r_out_r_q     <= 64'd0;
            r_out_tag_q   <= '0;
`ifdef MUL_ISSUE_TIMEOUT_EN
            r_out_err_q   <= 1'b0;
            r_wdog_q      <= 5'd0;
`endif
        end else begin
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_count_q     <= w_count_d;
            r_state_q     <= w_state_d;
            r_tag_q       <= w_tag_d;
            r_mul_valid_q <= w_mul_valid_d;
            r_mul_a_q     <= w_mul_a_d;
            r_mul_b_q     <= w_mul_b_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_r_q     <= w_out_r_d;
            r_out_tag_q   <= w_out_tag_d;
`ifdef MUL_ISSUE_TIMEOUT_EN
            r_out_err_q   <= w_out_err_d;
            r_wdog_q      <= w_wdog_d;
`endif
        end
    end

    assign mul_valid_in = r_mul_valid_q;
    assign mul_a        = r_mul_a_q;
    assign mul_b        = r_mul_b_q;
    assign out_valid    = r_out_valid_q;
    assign out_r        = r_out_r_q;
    assign out_tag      = r_out_tag_q;
`ifdef MUL_ISSUE_TIMEOUT_EN
    assign out_err      = r_out_err_q;
`else
    assign out_err      = 1'b0;
`endif
    assign busy         = !w_empty || (r_state_q != c_ST_IDLE);

endmodule
`default_nettype wire
